// File: rtl/dac_sample_scheduler.sv
// Two-channel sample scheduler feeding one SPI DAC serializer.
// Paces the sources, buffers one sample per channel, arbitrates round-robin.
module dac_sample_scheduler #(
    parameter int         WIDTH = 12,
    parameter int         DIV   = 2500,
    parameter logic [3:0] CMD0  = 4'h3,
    parameter logic [3:0] CMD1  = 4'h7
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               en,
    output logic               tick,
    input  logic               s0_valid,
    input  logic [WIDTH-1:0]   s0_data,
    input  logic               s1_valid,
    input  logic [WIDTH-1:0]   s1_data,
    input  logic               ovr_clr,
    output logic               spi_start,
    output logic [WIDTH+3:0]   spi_word,
    input  logic               spi_busy,
    output logic [1:0]         overrun,
    output logic [15:0]        frame_cnt
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [CW-1:0]    count;
    logic [1:0]       state;
    logic [WIDTH-1:0] hold0;
    logic [WIDTH-1:0] hold1;
    logic [1:0]       full;
    logic             last_grant;
    logic             grant;
    logic             gsel;
    logic [1:0]       gvec;
    logic [1:0]       ovr_set;

    assign tick      = en && (count == LAST);
    assign spi_start = (state == ISSUE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (!en || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Both holds full: the channel that did not win last time goes next
    always_comb begin
        grant = 1'b0;
        gsel  = 1'b0;
        if (state == IDLE && en && |full) begin
            grant = 1'b1;
            gsel  = (&full) ? ~last_grant : full[1];
        end
    end

    assign gvec    = {grant & gsel, grant & ~gsel};
    assign ovr_set = {s1_valid & full[1] & ~gvec[1],
                      s0_valid & full[0] & ~gvec[0]};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hold0   <= '0;
            hold1   <= '0;
            full    <= 2'b00;
            overrun <= 2'b00;
        end else begin
            if (s0_valid) begin
                hold0   <= s0_data;
                full[0] <= 1'b1;
            end else if (gvec[0]) begin
                full[0] <= 1'b0;
            end
            if (s1_valid) begin
                hold1   <= s1_data;
                full[1] <= 1'b1;
            end else if (gvec[1]) begin
                full[1] <= 1'b0;
            end
            overrun <= ovr_set | (overrun & ~{2{ovr_clr}});
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            spi_word   <= '0;
            frame_cnt  <= 16'd0;
            last_grant <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        spi_word   <= gsel ? {CMD1, hold1} : {CMD0, hold0};
                        last_grant <= gsel;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= spi_busy ? WAIT_DONE : WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (spi_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!spi_busy) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Randomised bench for dac_sample_scheduler with a behavioural reference
// model, directed scenarios and a serializer model driving spi_busy.
module tb_dac_sample_scheduler;

    localparam int DIV = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        en = 1'b0;
    logic        tick;
    logic        s0_valid = 1'b0;
    logic [11:0] s0_data = '0;
    logic        s1_valid = 1'b0;
    logic [11:0] s1_data = '0;
    logic        ovr_clr = 1'b0;
    logic        spi_start;
    logic [15:0] spi_word;
    logic        spi_busy = 1'b0;
    logic [1:0]  overrun;
    logic [15:0] frame_cnt;

    dac_sample_scheduler #(
        .WIDTH(12), .DIV(DIV), .CMD0(4'h3), .CMD1(4'h7)
    ) dut (
        .clock(clock), .resetn(resetn), .en(en), .tick(tick),
        .s0_valid(s0_valid), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_data(s1_data),
        .ovr_clr(ovr_clr), .spi_start(spi_start), .spi_word(spi_word),
        .spi_busy(spi_busy), .overrun(overrun), .frame_cnt(frame_cnt)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // reference model: phase 0 idle, 1 start pulse, 2 awaiting busy, 3 busy
    int          m_cnt;
    int          m_phase;
    logic [11:0] m_hold [2];
    logic [1:0]  m_full;
    int          m_last;
    logic [15:0] m_word;
    logic [15:0] m_frames;
    logic [1:0]  m_ovr;

    int blen_fix = 0;
    int rem = 0;
    int dly = 0;
    logic [15:0] words_q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_phase = 0; m_full = 2'b00; m_last = 1;
        m_word = '0; m_frames = '0; m_ovr = 2'b00;
        m_hold[0] = '0; m_hold[1] = '0;
    endtask

    task automatic model_step();
        int g;
        logic [1:0] so;
        logic [1:0] v;
        logic [11:0] d [2];
        g = -1;
        v = {s1_valid, s0_valid};
        d[0] = s0_data; d[1] = s1_data;
        if (m_phase == 0 && en && m_full != 2'b00)
            g = (m_full == 2'b11) ? 1 - m_last : (m_full[0] ? 0 : 1);
        for (int x = 0; x < 2; x++)
            so[x] = v[x] && m_full[x] && (g != x);
        case (m_phase)
            1: m_phase = spi_busy ? 3 : 2;
            2: if (spi_busy) m_phase = 3;
            3: if (!spi_busy) begin m_frames = m_frames + 16'd1; m_phase = 0; end
            default: ;
        endcase
        if (g >= 0) begin
            m_word = {(g == 1) ? 4'h7 : 4'h3, m_hold[g]};
            m_full[g] = 1'b0;
            m_last = g;
            m_phase = 1;
        end
        for (int x = 0; x < 2; x++) begin
            if (v[x]) begin m_hold[x] = d[x]; m_full[x] = 1'b1; end
            if (so[x]) m_ovr[x] = 1'b1;
            else if (ovr_clr) m_ovr[x] = 1'b0;
        end
        m_cnt = en ? ((m_cnt == DIV - 1) ? 0 : m_cnt + 1) : 0;
    endtask

    task automatic compare();
        chk("tick", tick, en && (m_cnt == DIV - 1));
        chk("spi_start", spi_start, m_phase == 1);
        chk("spi_word", spi_word, m_word);
        chk("overrun", overrun, m_ovr);
        chk("frame_cnt", frame_cnt, m_frames);
    endtask

    // serializer: busy rises 0..2 cycles after the start pulse
    task automatic cyc();
        if (spi_start) begin
            words_q.push_back(spi_word);
            dly = $urandom_range(0, 2);
            rem = (blen_fix > 0) ? blen_fix : $urandom_range(1, 6);
        end
        if (dly > 0) begin spi_busy = 1'b0; dly--; end
        else if (rem > 0) begin spi_busy = 1'b1; rem--; end
        else spi_busy = 1'b0;
        @(posedge clock);
        if (!resetn) model_reset();
        else model_step();
        @(negedge clock);
        compare();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((m_phase != 0 || m_full != 2'b00) && n < bound) begin
            cyc();
            n++;
        end
        chk("drain_timeout", n < bound, 1);
    endtask

    task automatic pulse(input logic c1, input logic c0,
                         input logic [11:0] d1, input logic [11:0] d0);
        s0_valid = c0; s0_data = d0;
        s1_valid = c1; s1_data = d1;
        cyc();
        s0_valid = 1'b0; s1_valid = 1'b0;
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) @(negedge clock);
        chk("rst_tick", tick, 0);
        chk("rst_start", spi_start, 0);
        chk("rst_word", spi_word, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_frames", frame_cnt, 0);
        resetn = 1'b1;
        repeat (2) cyc();

        for (int i = 0; i < 16; i++) begin
            en = (i < 9 || i >= 12);
            #1;
            chk("tick_seq", tick, (i == 3 || i == 7 || i == 15));
            #1;
            cyc();
        end
        en = 1'b1;

        blen_fix = 4;
        words_q.delete();
        pulse(1'b1, 1'b1, 12'hABC, 12'h123);
        drain(200);
        pulse(1'b1, 1'b1, 12'h789, 12'h456);
        drain(200);
        chk("rr_count", words_q.size(), 4);
        if (words_q.size() == 4) begin
            chk("rr_w0", words_q[0], 16'h3123);
            chk("rr_w1", words_q[1], 16'h7ABC);
            chk("rr_w2", words_q[2], 16'h3456);
            chk("rr_w3", words_q[3], 16'h7789);
        end

        blen_fix = 16;
        words_q.delete();
        pulse(1'b0, 1'b1, 12'h000, 12'h7FF);
        drain(200);
        chk("single_starts", words_q.size(), 1);
        if (words_q.size() == 1) chk("single_word", words_q[0], 16'h37FF);
        chk("single_frames", frame_cnt, 5);

        words_q.delete();
        pulse(1'b0, 1'b1, 12'h000, 12'h111);
        repeat (2) cyc();
        pulse(1'b1, 1'b0, 12'h001, 12'h000);
        cyc();
        pulse(1'b1, 1'b0, 12'h002, 12'h000);
        chk("ovr_set", overrun, 2'b10);
        drain(200);
        chk("ovr_frames", words_q.size(), 2);
        if (words_q.size() == 2) begin
            chk("ovr_w0", words_q[0], 16'h3111);
            chk("ovr_w1", words_q[1], 16'h7002);
        end
        ovr_clr = 1'b1;
        cyc();
        ovr_clr = 1'b0;
        chk("ovr_clr", overrun, 2'b00);

        pulse(1'b0, 1'b1, 12'h000, 12'h555);
        n = 0;
        while (m_phase != 3 && n < 50) begin cyc(); n++; end
        chk("reach_wait_done", m_phase, 3);
        resetn = 1'b0;
        rem = 0; dly = 0; spi_busy = 1'b0;
        #1;
        model_reset();
        chk("arst_start", spi_start, 0);
        chk("arst_word", spi_word, 0);
        chk("arst_ovr", overrun, 0);
        chk("arst_frames", frame_cnt, 0);
        cyc();
        resetn = 1'b1;
        words_q.delete();
        pulse(1'b0, 1'b1, 12'h000, 12'h666);
        drain(200);
        chk("post_rst_frames", frame_cnt, 1);
        if (words_q.size() == 1) chk("post_rst_word", words_q[0], 16'h3666);
        else chk("post_rst_starts", words_q.size(), 1);

        blen_fix = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) en = ~en;
            s0_valid = ($urandom_range(0, 7) == 0);
            s1_valid = ($urandom_range(0, 7) == 0);
            s0_data = 12'($urandom);
            s1_data = 12'($urandom);
            ovr_clr = ($urandom_range(0, 29) == 0);
            cyc();
        end
        s0_valid = 1'b0; s1_valid = 1'b0; ovr_clr = 1'b0;
        en = 1'b1;
        drain(500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
